// File: rtl/circular_right_shift.sv
// Registered circular right-rotate: out[i] = in[(i + k) mod WIDTH], one cycle latency.
// Define CRS_DYNAMIC_AMT_EN to add the per-beat `amt` port; otherwise k = SHIFT mod WIDTH.
module circular_right_shift #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned SHIFT = 7
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   input  logic [WIDTH-1:0]           in,
`ifdef CRS_DYNAMIC_AMT_EN
   input  logic [$clog2(WIDTH)-1:0]   amt,
`endif
   output logic [WIDTH-1:0]           out,
   output logic                       out_valid
);

   localparam int unsigned KW = $clog2(WIDTH);

   logic [KW-1:0]    k_c;
   logic [WIDTH-1:0] rot_c;
   logic [WIDTH-1:0] out_d, out_q;
   logic             out_valid_d, out_valid_q;

`ifdef CRS_DYNAMIC_AMT_EN
   // amt wraps for non-power-of-2 widths
   always_comb begin
      k_c = KW'(32'(amt) % WIDTH);
   end
`else
   localparam int unsigned K_STATIC = SHIFT % WIDTH;

   always_comb begin
      k_c = KW'(K_STATIC);
   end
`endif

   // Shifting the doubled word brings LSB-side bits back in at the MSB end
   always_comb begin
      rot_c = WIDTH'({in, in} >> k_c);
   end

   always_comb begin
      out_d       = out_q;
      out_valid_d = 1'b0;
      if (in_valid) begin
         out_d       = rot_c;
         out_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out       = out_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_circular_right_shift.sv
// Self-checking bench for circular_right_shift (WIDTH=8, SHIFT=7); honours CRS_DYNAMIC_AMT_EN.
module tb_circular_right_shift;

   typedef struct {
      logic [7:0] din;
      logic [2:0] a;
      logic [7:0] exp;
   } vec_t;

   typedef struct {
      logic       valid;
      logic [7:0] data;
   } sb_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic [7:0] in;
   logic [2:0] amt;
   logic [7:0] out;
   logic       out_valid;

   int  n_checks = 0;
   int  n_fail   = 0;
   sb_t sb_q[$];
   logic [7:0] last_out = 8'h00;

   circular_right_shift #(.WIDTH(8), .SHIFT(7)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in        (in),
`ifdef CRS_DYNAMIC_AMT_EN
      .amt       (amt),
`endif
      .out       (out),
      .out_valid (out_valid)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] rot_ref(input logic [7:0] d, input logic [2:0] a);
      logic [7:0] r;
      int unsigned k;
`ifdef CRS_DYNAMIC_AMT_EN
      k = 32'(a);
`else
      k = 7 + 32'(a & 3'd0);
`endif
      for (int i = 0; i < 8; i++) r[i] = d[(i + k) % 8];
      return r;
   endfunction

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Drive one cycle, push the expected registered result, compare #1 after the edge
   task automatic drive(input string name, input logic rst, input logic v,
                        input logic [7:0] d, input logic [2:0] a, input logic [7:0] exp_data);
      sb_t e, got;
      rst_n = rst; in_valid = v; in = d; amt = a;
      if (!rst)   begin e.valid = 1'b0; e.data = 8'h00;    end
      else if (v) begin e.valid = 1'b1; e.data = exp_data; end
      else        begin e.valid = 1'b0; e.data = last_out; end
      last_out = e.data;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      got = sb_q.pop_front();
      check({name, ".out"}, out, got.data);
      check({name, ".out_valid"}, {7'd0, out_valid}, {7'd0, got.valid});
   endtask

   initial begin
      vec_t vecs[$];
      logic [7:0] d;
      logic       v;

      // Rotate right by 7 equals rotate left by 1 in both builds when amt=7
      vecs.push_back('{8'b00000001, 3'd7, 8'b00000010});
      vecs.push_back('{8'b10000000, 3'd7, 8'b00000001});
      vecs.push_back('{8'b11110000, 3'd7, 8'b11100001});
`ifdef CRS_DYNAMIC_AMT_EN
      vecs.push_back('{8'b10110001, 3'd0, 8'b10110001});
      vecs.push_back('{8'b10110001, 3'd1, 8'b11011000});
      vecs.push_back('{8'b10110001, 3'd4, 8'b00011011});
      vecs.push_back('{8'b10110001, 3'd7, 8'b01100011});
      vecs.push_back('{8'b11110000, 3'd7, 8'b11100001});
`endif

      rst_n = 1'b0; in_valid = 1'b0; in = 8'h00; amt = 3'd0;

      drive("reset0", 1'b0, 1'b1, 8'hFF, 3'd7, 8'h00);
      drive("reset1", 1'b0, 1'b1, 8'hFF, 3'd7, 8'h00);

      foreach (vecs[i]) drive($sformatf("vec%0d", i), 1'b1, 1'b1, vecs[i].din, vecs[i].a, vecs[i].exp);

      drive("hold0", 1'b1, 1'b0, 8'hAA, 3'd7, 8'h00);
      drive("hold1", 1'b1, 1'b0, 8'hAA, 3'd7, 8'h00);
      check("hold.value", out, 8'b11100001);

      drive("b2b0", 1'b1, 1'b1, 8'h81, 3'd7, 8'h03);
      drive("b2b1", 1'b1, 1'b1, 8'h3C, 3'd7, 8'h78);
      drive("b2b2", 1'b1, 1'b1, 8'hFF, 3'd7, 8'hFF);

      drive("mid0",   1'b1, 1'b1, 8'h81, 3'd7, 8'h03);
      drive("midrst", 1'b0, 1'b1, 8'h3C, 3'd7, 8'h00);
      drive("mid1",   1'b1, 1'b1, 8'h0F, 3'd7, 8'h1E);
      drive("mid2",   1'b1, 1'b0, 8'h55, 3'd7, 8'h00);

      for (int i = 0; i < 40; i++) begin
         d = 8'($urandom);
         v = 1'($urandom_range(0, 3) != 0);
`ifdef CRS_DYNAMIC_AMT_EN
         amt = 3'($urandom);
`else
         amt = 3'd7;
`endif
         drive($sformatf("rand%0d", i), 1'b1, v, d, amt, rot_ref(d, amt));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
